// File: rtl/fan_speed_ctrl_if.sv
// Sample-in / command-out bundle between the temperature source and fan_speed_ctrl.
// The master side supplies samples; the controller (slave) drives speed and mode.
interface fan_speed_ctrl_if;
   logic [7:0] temp;
   logic       temp_valid;
   logic [7:0] speed;
   logic [1:0] mode;
   logic       cool_on;
   logic       heat_on;

   modport master (
      output temp, temp_valid,
      input  speed, mode, cool_on, heat_on
   );

   modport slave (
      input  temp, temp_valid,
      output speed, mode, cool_on, heat_on
   );
endinterface

// File: rtl/fan_speed_ctrl.sv
// Thermostatic fan controller: IDLE/COOL/HEAT/DRAIN FSM with hysteresis, and a
// rate-limited speed ramp that tracks a saturated proportional target.
module fan_speed_ctrl #(
   parameter int unsigned T_LOW    = 15,
   parameter int unsigned T_HIGH   = 35,
   parameter int unsigned HYST     = 2,
   parameter int unsigned GAIN     = 8,
   parameter int unsigned STEP     = 4,
   parameter int unsigned RAMP_DIV = 16
) (
   input  logic              clk,
   input  logic              arst,
   fan_speed_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COOL  = 2'd1,
      HEAT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [7:0]  TH      = 8'(T_HIGH);
   localparam logic [7:0]  TL      = 8'(T_LOW);
   localparam logic [7:0]  TH_EXIT = 8'(T_HIGH - HYST);
   localparam logic [7:0]  TL_EXIT = 8'(T_LOW + HYST);
   localparam logic [7:0]  STEP8   = 8'(STEP);
   localparam logic [15:0] CNT_MAX = 16'(RAMP_DIV - 1);

   state_t      state_q, state_d;
   logic        cool_q, heat_q;
   logic [7:0]  temp_q;
   logic        have_q;
   logic [15:0] cnt_q;
   logic [7:0]  speed_q, speed_d;
   logic [31:0] prod;
   logic [7:0]  target;
   logic        ramp_tick;

   function automatic logic [7:0] sat8(input logic [31:0] v);
      return (v > 32'd255) ? 8'hFF : v[7:0];
   endfunction

   // Move cur toward tgt by at most STEP8, landing exactly on tgt when close.
   function automatic logic [7:0] ramp_step(input logic [7:0] cur, input logic [7:0] tgt);
      if (tgt >= cur) begin
         return ((tgt - cur) <= STEP8) ? tgt : cur + STEP8;
      end else begin
         return ((cur - tgt) <= STEP8) ? tgt : cur - STEP8;
      end
   endfunction

   assign ramp_tick = (cnt_q == CNT_MAX);

   // Target comes from the registered sample and state, so a sample arriving on a
   // tick edge only influences the following tick.
   always_comb begin
      prod = '0;
      case (state_q)
         COOL:    if (temp_q > TH) prod = 32'(temp_q - TH) * 32'(GAIN);
         HEAT:    if (temp_q < TL) prod = 32'(TL - temp_q) * 32'(GAIN);
         default: prod = '0;
      endcase
      target = sat8(prod);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (have_q && temp_q > TH)      state_d = COOL;
            else if (have_q && temp_q < TL) state_d = HEAT;
         end
         COOL:    if (temp_q < TH_EXIT) state_d = DRAIN;
         HEAT:    if (temp_q > TL_EXIT) state_d = DRAIN;
         DRAIN:   if (speed_q == 8'd0)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q <= IDLE;
         cool_q  <= 1'b0;
         heat_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cool_q  <= (state_d == COOL);
         heat_q  <= (state_d == HEAT);
      end
   end

   assign speed_d = ramp_tick ? ramp_step(speed_q, target) : speed_q;

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         temp_q  <= 8'd0;
         have_q  <= 1'b0;
         cnt_q   <= 16'd0;
         speed_q <= 8'd0;
      end else begin
         if (bus.temp_valid) begin
            temp_q <= bus.temp;
            have_q <= 1'b1;
         end
         cnt_q   <= ramp_tick ? 16'd0 : cnt_q + 16'd1;
         speed_q <= speed_d;
      end
   end

   assign bus.speed   = speed_q;
   assign bus.mode    = state_q;
   assign bus.cool_on = cool_q;
   assign bus.heat_on = heat_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
// Directed bench for fan_speed_ctrl: expected ramp values are queued as each
// scenario is driven and popped on every ramp tick.
module tb_fan_speed_ctrl;
   localparam int RAMP_DIV = 16;
   localparam int STEP     = 4;

   logic clk  = 1'b0;
   logic arst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   exp_q[$];

   fan_speed_ctrl_if bus ();

   fan_speed_ctrl #(
      .T_LOW(15), .T_HIGH(35), .HYST(2), .GAIN(8), .STEP(STEP), .RAMP_DIV(RAMP_DIV)
   ) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Edges since reset release; a ramp tick lands on every RAMP_DIV-th edge.
   always @(posedge clk or negedge arst) begin
      if (!arst) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] t);
      bus.temp       = t;
      bus.temp_valid = 1'b1;
      edge1();
      bus.temp_valid = 1'b0;
   endtask

   task automatic tick_wait();
      do edge1(); while ((cyc % RAMP_DIV) != 0);
   endtask

   task automatic tick_pop(input string tag);
      int e;
      tick_wait();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
      check(tag, bus.speed, e);
   endtask

   task automatic push_ramp(input int from, input int to);
      int v;
      v = from;
      while (v != to) begin
         if (to > v) v = (to - v <= STEP) ? to : v + STEP;
         else        v = (v - to <= STEP) ? to : v - STEP;
         exp_q.push_back(v);
      end
   endtask

   initial begin
      bus.temp       = 8'd0;
      bus.temp_valid = 1'b0;
      #1 arst = 1'b0;
      #11;
      check("reset_speed", bus.speed, 0);
      check("reset_mode", bus.mode, 0);
      check("reset_cool_on", bus.cool_on, 0);
      check("reset_heat_on", bus.heat_on, 0);
      @(negedge clk) arst = 1'b1;
      repeat (20) edge1();
      check("idle_no_sample", bus.mode, 0);

      // Cool entry at 45 C, ramp 0 -> 80
      send(8'd45);
      check("mode_after_latch_edge", bus.mode, 0);
      edge1();
      check("cool_mode", bus.mode, 1);
      check("cool_on", bus.cool_on, 1);
      check("cool_heat_off", bus.heat_on, 0);
      push_ramp(0, 80);
      tick_pop("ramp_up_80");
      repeat (8) edge1();
      check("hold_between_ticks", bus.speed, 4);
      repeat (19) tick_pop("ramp_up_80");
      tick_wait();
      check("hold_at_80", bus.speed, 80);

      // Cool hysteresis, drain, then heat re-entry
      send(8'd34);
      edge1();
      check("cool_hyst_stay", bus.mode, 1);
      push_ramp(80, 72);
      repeat (2) tick_pop("cool_ramp_down");
      send(8'd32);
      edge1();
      check("drain_mode", bus.mode, 3);
      check("drain_cool_off", bus.cool_on, 0);
      push_ramp(72, 40);
      repeat (8) tick_pop("drain_ramp");
      send(8'd5);
      edge1();
      check("drain_ignores_cold", bus.mode, 3);
      push_ramp(40, 0);
      repeat (10) tick_pop("drain_to_zero");
      check("drain_at_zero", bus.mode, 3);
      edge1();
      check("drain_to_idle", bus.mode, 0);
      edge1();
      check("idle_to_heat", bus.mode, 2);
      check("heat_on", bus.heat_on, 1);
      push_ramp(0, 80);
      repeat (20) tick_pop("heat_ramp_80");

      // Sample landing on a tick edge
      while ((cyc % RAMP_DIV) != RAMP_DIV - 1) edge1();
      send(8'd0);
      check("coincident_tick_old_target", bus.speed, 80);
      tick_wait();
      check("next_tick_new_target", bus.speed, 84);

      send(8'd17);
      edge1();
      check("heat_hyst_stay", bus.mode, 2);
      send(8'd18);
      edge1();
      check("heat_exit_drain", bus.mode, 3);
      check("heat_off_in_drain", bus.heat_on, 0);

      // Reset mid-ramp in COOL at speed 120
      arst = 1'b0;
      #3;
      @(negedge clk) arst = 1'b1;
      send(8'd50);
      push_ramp(0, 120);
      repeat (30) tick_pop("ramp_to_120");
      check("cool_before_reset", bus.mode, 1);
      @(posedge clk);
      #3 arst = 1'b0;
      #1;
      check("async_reset_speed", bus.speed, 0);
      check("async_reset_mode", bus.mode, 0);
      check("async_reset_cool_on", bus.cool_on, 0);
      repeat (3) @(negedge clk);
      check("held_reset_speed", bus.speed, 0);
      arst = 1'b1;
      repeat (20) edge1();
      check("idle_after_reset", bus.mode, 0);
      check("speed_after_reset", bus.speed, 0);

      // Saturation: 100 C gives 520, clamps to 255
      send(8'd100);
      check("idle_until_latched", bus.mode, 0);
      edge1();
      check("sat_cool_mode", bus.mode, 1);
      push_ramp(0, 255);
      repeat (64) tick_pop("sat_ramp");
      tick_wait();
      check("sat_hold_255", bus.speed, 255);
      check("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fan_speed_ctrl.md
FAN_SPEED_CTRL -- requirements
Module: fan_speed_ctrl

Interface
REQ-001 Parameter T_LOW, default 15: heat threshold in °C, unsigned 8-bit.
REQ-002 Parameter T_HIGH, default 35: cool threshold in °C; T_HIGH > T_LOW + 2*HYST.
REQ-003 Parameter HYST, default 2: hysteresis in °C for leaving COOL or HEAT.
REQ-004 Parameter GAIN, default 8: target-speed counts per °C of error.
REQ-005 Parameter STEP, default 4: maximum speed change per ramp tick, range 1..255.
REQ-006 Parameter RAMP_DIV, default 16: clocks per ramp tick, range 2..65535.
REQ-007 clk  input  1  clock; all state changes on the rising edge.
REQ-008 arst  input  1  reset; asynchronous, active-low.
REQ-009 temp  input  8  temperature sample, unsigned °C.
REQ-010 temp_valid  input  1  single-cycle strobe qualifying temp.
REQ-011 speed  output  8  registered duty-cycle command to the downstream PWM stage.
REQ-012 mode  output  2  FSM state: IDLE=0, COOL=1, HEAT=2, DRAIN=3.
REQ-013 cool_on  output  1  high only in COOL.
REQ-014 heat_on  output  1  high only in HEAT.

Function
REQ-015 temp_reg SHALL load temp on each edge where temp_valid=1; have_sample SHALL set on the first such load and stay set until reset.
REQ-016 The FSM SHALL evaluate transitions only from temp_reg, so a new sample affects mode on the second edge after temp_valid.
REQ-017 IDLE SHALL move to COOL if have_sample and temp_reg > T_HIGH, else to HEAT if have_sample and temp_reg < T_LOW, else remain in IDLE; without have_sample it SHALL remain in IDLE.
REQ-018 COOL SHALL move to DRAIN when temp_reg < T_HIGH - HYST.
REQ-019 HEAT SHALL move to DRAIN when temp_reg > T_LOW + HYST.
REQ-020 DRAIN SHALL move to IDLE on the edge after speed reaches 0; a direct COOL<->HEAT transition is forbidden.
REQ-021 Target speed in COOL SHALL be (temp_reg - T_HIGH)*GAIN when temp_reg > T_HIGH, else 0.
REQ-022 Target speed in HEAT SHALL be (T_LOW - temp_reg)*GAIN when temp_reg < T_LOW, else 0.
REQ-023 Target speed in IDLE and DRAIN SHALL be 0.
REQ-024 The target computation SHALL use at least 16-bit intermediates and saturate to 255; no wrap-around is allowed.
REQ-025 A free-running tick counter SHALL count 0..RAMP_DIV-1 and wrap to 0; ramp_tick is asserted when the count equals RAMP_DIV-1.
REQ-026 On ramp_tick, speed SHALL move toward target by STEP.
REQ-027 On ramp_tick, if |target - speed| <= STEP, speed SHALL equal target exactly, with no overshoot and no 8-bit wrap.
REQ-028 Between ticks, speed SHALL hold its value.
REQ-029 When temp_valid and ramp_tick coincide, the ramp SHALL use the target derived from the old temp_reg and state.
REQ-030 cool_on, heat_on and mode SHALL be registered and decode directly from the state register.

Reset
REQ-031 While arst=0, asynchronously: speed=0, mode=IDLE, cool_on=0, heat_on=0, temp_reg=0, have_sample=0, tick counter=0.
REQ-032 Reset asserted mid-ramp or mid-DRAIN SHALL abort immediately with no residual ramp.
REQ-033 After arst rises, the block SHALL remain in IDLE until a valid sample arrives.

Verification
REQ-034 Pulse arst low while speed=120 in COOL -> speed=0 and mode=0 before the next clk edge; later temp_valid with no prior sample keeps IDLE until the sample is latched.
REQ-035 temp=45 with temp_valid -> mode=1 and cool_on=1 two edges later; target=80; speed rises 0,4,...,80, one step every 16 clocks, and reaches 80 after 20 ticks.
REQ-036 temp=100 with temp_valid -> target saturates at 255 (not 520 mod 256); the final ramp step goes 252->255 and speed then holds at 255.
REQ-037 In COOL at speed 80: temp=34 -> mode stays 1 and target=0, so speed ramps down; temp=32 -> mode=3 and cool_on=0; speed ramps to 0; mode=0 one edge after speed=0.
REQ-038 In DRAIN at speed 40, temp=5 -> mode stays 3 until speed=0, then goes 3->0->2; heat_on=1 and target=80.
REQ-039 temp_valid coincident with ramp_tick -> that tick steps toward the old target, and the next tick steps toward the new target.
